// File: rtl/lmsm_pkg.sv
// Shared constants and types for the LM/SM micro-op expander.
package lmsm_pkg;

   localparam int          IW      = 16;
   localparam logic [15:0] NOP_IR  = 16'hF000;

   localparam logic [3:0]  OP_LW   = 4'b0100;
   localparam logic [3:0]  OP_SW   = 4'b0101;
   localparam logic [3:0]  OP_LM   = 4'b0110;
   localparam logic [3:0]  OP_SM   = 4'b0111;

   localparam int          OPC_HI  = 15;
   localparam int          OPC_LO  = 12;
   localparam int          RA_HI   = 11;
   localparam int          RA_LO   = 9;
   localparam int          LIST_HI = 7;
   localparam int          LIST_LO = 0;

   typedef enum logic {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } state_t;

endpackage

// File: rtl/lmsm_pick.sv
// Chooses the next register of an LM/SM list and its memory offset.
// The base register of an LM is held back until it is the only one left,
// so the remaining loads still address from the original base value.
// The offset counts only original-list bits, so the memory layout does not
// depend on issue order.
module lmsm_pick (
   input  logic [7:0] mask,
   input  logic [7:0] list,
   input  logic [2:0] base,
   input  logic       is_lm,
   output logic [2:0] idx,
   output logic [5:0] k,
   output logic       rest_empty
);

   logic [7:0] base_bit;
   logic [7:0] cand;
   logic [7:0] rest;
   logic       defer;
   logic [2:0] cnt;

   // priority pick with base deferral, then popcount of lower list bits
   always_comb begin
      base_bit = 8'b1 << base;
      defer    = is_lm & (|(mask & base_bit)) & (|(mask & ~base_bit));
      cand     = defer ? (mask & ~base_bit) : mask;

      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (cand[i]) idx = 3'(i);
      end

      cnt = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((i < int'(idx)) && list[i]) cnt = cnt + 3'd1;
      end
      k = {3'b000, cnt};

      rest       = mask & ~(8'b1 << idx);
      rest_empty = (rest == 8'd0);
   end

endmodule

// File: rtl/lmsm_expander.sv
// Expands LM/SM into one LW/SW per listed register; everything else passes
// through with one cycle of latency. Fetch is held while a sequence runs.
//
// state | meaning
// IDLE  | ready for a new instruction; output holds last op (or nothing)
// SEQ   | LM/SM micro-ops still pending in mask_q; fetch is held
module lmsm_expander #(
   parameter int            IW     = 16,
   parameter logic [IW-1:0] NOP_IR = lmsm_pkg::NOP_IR
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [IW-1:0] in_ir,
   input  logic [IW-1:0] in_pc,
   input  logic [IW-1:0] in_npc,
   output logic          in_ready,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [IW-1:0] out_ir,
   output logic [IW-1:0] out_pc,
   output logic [IW-1:0] out_npc,
   output logic          out_last
);

   import lmsm_pkg::*;

   state_t        state_q, state_d;
   logic [7:0]    mask_q, mask_d;
   logic [7:0]    list_q, list_d;
   logic [2:0]    base_q, base_d;
   logic          is_lm_q, is_lm_d;
   logic          out_valid_d;
   logic [IW-1:0] out_ir_d, out_pc_d, out_npc_d;
   logic          out_last_d;

   logic [3:0]    in_opc;
   logic          in_is_lm, in_is_lmsm;
   logic [7:0]    in_list;
   logic [2:0]    in_base;
   logic          accept;

   logic [7:0]    pick_mask, pick_list, pick_rest;
   logic [2:0]    pick_base, pick_idx;
   logic          pick_lm, pick_empty;
   logic [5:0]    pick_k;
   logic [15:0]   uop;

   assign in_opc     = in_ir[OPC_HI:OPC_LO];
   assign in_is_lm   = (in_opc == OP_LM);
   assign in_is_lmsm = in_is_lm | (in_opc == OP_SM);
   assign in_list    = in_ir[LIST_HI:LIST_LO];
   assign in_base    = in_ir[RA_HI:RA_LO];

   assign in_ready = resetn & ~flush & out_ready & (state_q == IDLE);
   assign accept   = in_ready & in_valid;

   // in IDLE the picker works on the incoming instruction so the first
   // micro-op leaves in the same registered cycle as the capture
   assign pick_mask = (state_q == SEQ) ? mask_q  : in_list;
   assign pick_list = (state_q == SEQ) ? list_q  : in_list;
   assign pick_base = (state_q == SEQ) ? base_q  : in_base;
   assign pick_lm   = (state_q == SEQ) ? is_lm_q : in_is_lm;
   assign pick_rest = pick_mask & ~(8'b1 << pick_idx);
   assign uop       = {(pick_lm ? OP_LW : OP_SW), pick_idx, pick_base, pick_k};

   lmsm_pick u_pick (
      .mask       (pick_mask),
      .list       (pick_list),
      .base       (pick_base),
      .is_lm      (pick_lm),
      .idx        (pick_idx),
      .k          (pick_k),
      .rest_empty (pick_empty)
   );

   // next-state and output-register values; everything holds by default
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      list_d      = list_q;
      base_d      = base_q;
      is_lm_d     = is_lm_q;
      out_valid_d = out_valid;
      out_ir_d    = out_ir;
      out_pc_d    = out_pc;
      out_npc_d   = out_npc;
      out_last_d  = out_last;

      if (flush) begin
         state_d     = IDLE;
         mask_d      = 8'd0;
         out_valid_d = 1'b0;
         out_ir_d    = NOP_IR;
         out_last_d  = 1'b0;
      end else if (out_ready) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  out_valid_d = 1'b1;
                  out_pc_d    = in_pc;
                  out_npc_d   = in_npc;
                  out_last_d  = 1'b1;
                  if (!in_is_lmsm) begin
                     out_ir_d = in_ir;
                  end else if (in_list == 8'd0) begin
                     out_ir_d = NOP_IR;
                  end else begin
                     list_d   = in_list;
                     base_d   = in_base;
                     is_lm_d  = in_is_lm;
                     mask_d   = pick_rest;
                     out_ir_d = IW'(uop);
                     if (!pick_empty) begin
                        out_last_d = 1'b0;
                        state_d    = SEQ;
                     end
                  end
               end else begin
                  out_valid_d = 1'b0;
               end
            end
            SEQ: begin
               out_valid_d = 1'b1;
               out_ir_d    = IW'(uop);
               mask_d      = pick_rest;
               out_last_d  = pick_empty;
               if (pick_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         mask_q    <= 8'd0;
         list_q    <= 8'd0;
         base_q    <= 3'd0;
         is_lm_q   <= 1'b0;
         out_valid <= 1'b0;
         out_ir    <= NOP_IR;
         out_pc    <= '0;
         out_npc   <= '0;
         out_last  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         list_q    <= list_d;
         base_q    <= base_d;
         is_lm_q   <= is_lm_d;
         out_valid <= out_valid_d;
         out_ir    <= out_ir_d;
         out_pc    <= out_pc_d;
         out_npc   <= out_npc_d;
         out_last  <= out_last_d;
      end
   end

endmodule

// File: doc/lmsm_expander.md
Name: lmsm_expander

Overview:
Micro-op sequencer placed between the IF/ID pipeline register and the ID-stage controller. It converts each LM or SM instruction into one LW or SW micro-op per set bit in its 8-bit register list, and holds fetch until the sequence completes. All other instructions pass through with one cycle of latency. The controller, ID/RD register and all later stages only ever see single-register memory ops.

Parameters:
IW, 16, instruction/PC width
NOP_IR, 16'hF000, encoding emitted for an empty LM/SM list and after reset/flush

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous, active-low reset
flush  in  1  branch-taken flush from the MEM stage; aborts any sequence
in_valid  in  1  IF/ID holds a valid instruction
in_ir  in  IW  instruction from IF/ID
in_pc  in  IW  PC of in_ir
in_npc  in  IW  PC+1 of in_ir
in_ready  out  1  instruction accepted this cycle; IF/ID may advance
out_ready  in  1  downstream can accept (low = stall)
out_valid  out  1  out_ir is valid
out_ir  out  IW  instruction or micro-op to the controller
out_pc  out  IW  PC of the originating instruction
out_npc  out  IW  NPC of the originating instruction
out_last  out  1  final (or only) op of the originating instruction

Behaviour:
- One clock domain (clk). resetn is synchronous and active-low.
- Reset: state=IDLE, mask=0, out_valid=0, out_ir=NOP_IR, out_pc=0, out_npc=0, out_last=0.
- in_ready = resetn & ~flush & out_ready & (state==IDLE). It is combinational.
- Priority order: reset > flush > out_ready low (all registers hold) > normal operation.
- Flush: next cycle state=IDLE, mask=0, out_valid=0, out_ir=NOP_IR, out_last=0. Any instruction presented in the flush cycle is dropped.
- Decode fields: opcode=in_ir[15:12]; LM=4'b0110; SM=4'b0111; base RA=in_ir[11:9]; list=in_ir[7:0], where bit i means Ri; in_ir[8] is ignored.
- IDLE, accepted, not LM/SM: out_ir<=in_ir, out_valid<=1, out_last<=1. Latency is 1 cycle.
- IDLE, accepted, LM/SM with list==0: out_ir<=NOP_IR, out_valid<=1, out_last<=1. State stays IDLE.
- IDLE, accepted, LM/SM with list!=0:
  - Capture op type, base, pc/npc and list into mask.
  - Emit the first micro-op in the same registered cycle.
  - Clear its bit from the remaining mask.
  - If the remaining mask is nonzero, go to SEQ with out_last=0; otherwise stay IDLE with out_last=1.
- SEQ, out_ready high: emit the next micro-op and clear its bit. When the remaining mask becomes empty, set out_last=1 and go to IDLE. The next instruction is accepted on the following cycle.
- Issue order:
  - Ascending register index.
  - For LM only, if the base register is in the list, its load is issued last, so the base is not overwritten before the other loads.
  - SM uses plain ascending order.
- Offset k for Ri = popcount(original list bits below i). The memory layout is therefore independent of issue order. k is 0..7, zero-extended to 6 bits.
- Micro-op encodings:
  - LM gives {4'b0100, Ri, base, k[5:0]}, i.e. LW Ri <- mem[base+k].
  - SM gives {4'b0101, Ri, base, k[5:0]}, i.e. SW mem[base+k] <- Ri.
- An n-bit list produces n output cycles (absent stalls). in_ready is low for cycles 1..n-1 of the sequence.
- Every micro-op carries the originating instruction's pc/npc.
- Reset or flush mid-sequence: the remaining micro-ops are discarded, with no partial re-issue.

Decomposition:
- Shared package lmsm_pkg:
  - opcode constants OP_LW, OP_SW, OP_LM, OP_SM
  - NOP_IR
  - state enum IDLE/SEQ
  - field-slice constants for RA and the list
- Sub-module lmsm_pick, combinational. Inputs: remaining mask, original list, base, is_lm. Outputs: selected register index, offset k, and remaining-after-pick empty flag. It contains the priority encoder with base-deferral and the popcount.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ir=16'hF000, out_last=0.
2. Pass-through: in_ir=16'h1050, pc=16'h0010 -> next cycle out_ir=16'h1050, out_pc=16'h0010, out_valid=1, out_last=1, in_ready=1 throughout.
3. LM with base in list: in_ir=16'h6425 (R2 base; R0, R2, R5 in list) -> out_ir sequence 16'h4080, 16'h4A82, 16'h4481. out_last=1 only on 16'h4481; in_ready=0 for the 2 middle cycles.
4. SM: in_ir=16'h7281 -> out_ir 16'h5040, then 16'h5E41 with out_last=1. Both carry the SM's pc/npc.
5. Empty list: in_ir=16'h6000 -> single out_ir=16'hF000, out_last=1, no fetch hold.
6. Stall then flush:
   - During 16'h6425, drop out_ready after the first micro-op for 3 cycles -> out_ir holds 16'h4080.
   - Assert flush on the cycle 16'h4A82 would issue -> next cycle out_valid=0, state IDLE, in_ready=1, and 16'h4481 is never emitted.
